// File: rtl/obstacle_spawner.sv
// Turns the LFSR word stream into timed obstacle spawn requests on a
// valid/ready handshake: one random word per obstacle, then a frame-counted gap.
module obstacle_spawner #(
    parameter int MIN_GAP    = 40,
    parameter int GAP_W      = 6,
    parameter int BIRD_AFTER = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        frame_i,
    input  logic        run_i,
    input  logic [15:0] rand_i,
    output logic        next_o,
    output logic        spawn_valid_o,
    output logic [1:0]  spawn_type_o,
    input  logic        spawn_ready_i,
    output logic [7:0]  spawn_count_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WAIT  = 2'd2,
        SPAWN = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [7:0]  gap_reg, gap_next;
    logic [1:0]  type_reg, type_next;
    logic [7:0]  count_reg, count_next;

    logic [7:0]  gap_load;
    logic [1:0]  raw_type;
    logic        bird_ok;

    assign gap_load = 8'(MIN_GAP) + 8'(rand_i[GAP_W-1:0]);
    assign raw_type = rand_i[15:14];
    // Gating looks at the live count, so it re-applies after the counter wraps.
    assign bird_ok  = int'(count_reg) >= BIRD_AFTER;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            gap_reg   <= 8'd0;
            type_reg  <= 2'd0;
            count_reg <= 8'd0;
        end else begin
            state_reg <= state_next;
            gap_reg   <= gap_next;
            type_reg  <= type_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        gap_next   = gap_reg;
        type_next  = type_reg;
        count_next = count_reg;
        // Stopping the game wins over everything, including a same-cycle accept.
        if (!run_i) begin
            state_next = IDLE;
            gap_next   = 8'd0;
        end else begin
            case (state_reg)
                IDLE: state_next = LOAD;
                LOAD: begin
                    gap_next   = gap_load;
                    type_next  = (raw_type == 2'd3 && !bird_ok) ? 2'd2 : raw_type;
                    state_next = WAIT;
                end
                WAIT: begin
                    if (frame_i) begin
                        gap_next = gap_reg - 8'd1;
                        if (gap_reg <= 8'd1) begin
                            state_next = SPAWN;
                        end
                    end
                end
                SPAWN: begin
                    if (spawn_ready_i) begin
                        count_next = count_reg + 8'd1;
                        state_next = LOAD;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // The LFSR advances on the same edge that captures its word.
    assign next_o        = (state_reg == LOAD);
    assign spawn_valid_o = (state_reg == SPAWN);
    assign spawn_type_o  = type_reg;
    assign spawn_count_o = count_reg;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Scoreboard bench for obstacle_spawner: directed scenarios push expected
// spawns, a monitor checks type, gap and count on every accepted handshake.
module tb_obstacle_spawner;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        frame_i = 1'b0;
    logic        run_i = 1'b0;
    logic [15:0] rand_i = 16'h0001;
    logic        spawn_ready_i = 1'b0;
    logic        next_o;
    logic        spawn_valid_o;
    logic [1:0]  spawn_type_o;
    logic [7:0]  spawn_count_o;

    obstacle_spawner #(.MIN_GAP(40), .GAP_W(6), .BIRD_AFTER(8)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .frame_i       (frame_i),
        .run_i         (run_i),
        .rand_i        (rand_i),
        .next_o        (next_o),
        .spawn_valid_o (spawn_valid_o),
        .spawn_type_o  (spawn_type_o),
        .spawn_ready_i (spawn_ready_i),
        .spawn_count_o (spawn_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0] typ;
        int         gap;
        logic [7:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          frame_per = 4;
    bit          frame_en = 1'b0;
    bit          force_en = 1'b0;
    logic [15:0] force_val = 16'h0000;
    logic [15:0] lfsr = 16'h0001;
    int          ph = 0;
    bit          nx = 1'b0;
    int          fcnt = 0;
    exp_t        e;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic wait_valid(input int maxc);
        int n = 0;
        while (!spawn_valid_o && n < maxc) begin
            @(negedge clk_i);
            n++;
        end
        check("wait_valid", 16'(spawn_valid_o), 16'd1);
    endtask

    task automatic wait_next(input int maxc);
        int n = 0;
        while (!next_o && n < maxc) begin
            @(negedge clk_i);
            n++;
        end
        check("wait_next", 16'(next_o), 16'd1);
    endtask

    task automatic wait_count(input logic [7:0] target, input int maxc);
        int n = 0;
        while (spawn_count_o !== target && n < maxc) begin
            @(negedge clk_i);
            n++;
        end
        check("wait_count", 16'(spawn_count_o), 16'(target));
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Input driver: LFSR model (x^16+x^14+x^13+x^11+1, shift left) and frame pulses.
    initial begin
        forever begin
            @(negedge clk_i);
            nx = next_o;
            @(posedge clk_i);
            #1;
            if (nx) lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            ph = (ph + 1) % frame_per;
            frame_i = frame_en && (ph == 0);
            rand_i = force_en ? force_val : lfsr;
        end
    end

    // Monitor: frames counted from the LFSR request until the request goes valid.
    initial begin
        forever begin
            @(negedge clk_i);
            if (spawn_valid_o && spawn_ready_i && run_i && rst_ni) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_spawn: got type %0d count %0d, required no spawn",
                             spawn_type_o, spawn_count_o);
                end else begin
                    e = sb_q.pop_front();
                    check("spawn_type", 16'(spawn_type_o), 16'(e.typ));
                    check("spawn_gap", 16'(fcnt), 16'(e.gap));
                    check("count_before", 16'(spawn_count_o), 16'(e.cnt));
                    $display("spawn accepted: type %0d gap %0d frames count_before %0d",
                             spawn_type_o, fcnt, spawn_count_o);
                end
            end
            if (!rst_ni || !run_i || next_o) fcnt = 0;
            else if (frame_i && !spawn_valid_o) fcnt++;
        end
    end

    initial begin
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_valid", 16'(spawn_valid_o), 16'd0);
        check("rst_next", 16'(next_o), 16'd0);
        check("rst_type", 16'(spawn_type_o), 16'd0);
        check("rst_count", 16'(spawn_count_o), 16'd0);
        step();
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("idle_valid", 16'(spawn_valid_o), 16'd0);
        check("idle_next", 16'(next_o), 16'd0);

        // LFSR-driven: seed 0x0001 gives gap 41, then 0x0002 gives gap 42.
        sb_q.push_back('{2'd0, 41, 8'd0});
        sb_q.push_back('{2'd0, 42, 8'd1});
        step();
        frame_en = 1'b1;
        spawn_ready_i = 1'b1;
        run_i = 1'b1;
        wait_count(8'd2, 2000);
        step();
        run_i = 1'b0;

        // Forced 0xC000: birds suppressed to type 2 until eight accepts.
        rst_ni = 1'b0;
        force_en = 1'b1;
        force_val = 16'hC000;
        frame_per = 1;
        step();
        rst_ni = 1'b1;
        for (int i = 0; i < 8; i++) sb_q.push_back('{2'd2, 40, 8'(i)});
        sb_q.push_back('{2'd3, 40, 8'd8});
        step();
        run_i = 1'b1;
        wait_count(8'd9, 1000);
        step();
        run_i = 1'b0;

        // Backpressure: request must hold steady while ready is low.
        force_val = 16'h4005;
        spawn_ready_i = 1'b0;
        sb_q.push_back('{2'd1, 45, 8'd9});
        step();
        run_i = 1'b1;
        wait_valid(200);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("stall_valid", 16'(spawn_valid_o), 16'd1);
            check("stall_type", 16'(spawn_type_o), 16'd1);
            check("stall_count", 16'(spawn_count_o), 16'd9);
            check("stall_next", 16'(next_o), 16'd0);
        end
        step();
        spawn_ready_i = 1'b1;
        wait_count(8'd10, 10);
        check("accept_next", 16'(next_o), 16'd1);
        check("accept_valid", 16'(spawn_valid_o), 16'd0);

        // Drop run mid-gap, then restart with a fresh load.
        force_val = 16'h0000;
        step();
        run_i = 1'b0;
        step();
        run_i = 1'b1;
        wait_next(10);
        repeat (20) @(negedge clk_i);
        step();
        run_i = 1'b0;
        @(negedge clk_i);
        check("drop_valid", 16'(spawn_valid_o), 16'd0);
        check("drop_next", 16'(next_o), 16'd0);
        repeat (3) @(negedge clk_i);
        check("drop_idle_valid", 16'(spawn_valid_o), 16'd0);
        sb_q.push_back('{2'd0, 40, 8'd10});
        step();
        run_i = 1'b1;
        @(negedge clk_i);
        check("restart_idle_next", 16'(next_o), 16'd0);
        @(negedge clk_i);
        check("restart_load_next", 16'(next_o), 16'd1);
        wait_count(8'd11, 200);

        // Stop and ready in the same SPAWN cycle: no accept.
        step();
        spawn_ready_i = 1'b0;
        wait_valid(200);
        step();
        run_i = 1'b0;
        spawn_ready_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        check("withdraw_valid", 16'(spawn_valid_o), 16'd0);
        check("withdraw_count", 16'(spawn_count_o), 16'd11);
        check("withdraw_next", 16'(next_o), 16'd0);

        // Asynchronous reset in the middle of a pending request.
        force_val = 16'h4000;
        step();
        spawn_ready_i = 1'b0;
        run_i = 1'b1;
        wait_valid(200);
        check("pre_rst_type", 16'(spawn_type_o), 16'd1);
        @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        check("async_rst_valid", 16'(spawn_valid_o), 16'd0);
        check("async_rst_count", 16'(spawn_count_o), 16'd0);
        check("async_rst_type", 16'(spawn_type_o), 16'd0);
        check("async_rst_next", 16'(next_o), 16'd0);
        run_i = 1'b0;
        step();
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("post_rst_valid", 16'(spawn_valid_o), 16'd0);
        check("post_rst_next", 16'(next_o), 16'd0);
        step();
        run_i = 1'b1;
        @(negedge clk_i);
        check("post_rst_idle_next", 16'(next_o), 16'd0);
        @(negedge clk_i);
        check("post_rst_load_next", 16'(next_o), 16'd1);
        check("scoreboard_empty", 16'(sb_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
